spi_periph_t: RTL and testbench
===============================

// Module: spi_periph_t
// PURPOSE
//   Memory-mapped SPI peripheral (target) for the rv32i SoC: the responder end of the SPI
//   bus driven by a host SPI master. Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
//   Sits on the CPU peripheral bus beside the UART/SPI/GPIO blocks and exposes a receive
//   register, a single-entry transmit buffer, a fill byte and status flags.
// PARAMETERS
//   SYNC_STAGES  2      flops per input synchronizer on sck/cs/mosi (min 2)
//   FILL_RESET   8'hFF  reset value of FILL register (sent when no TX byte pending)
// PORTS
//   clk      in   1   system clock; the only clock, all logic on posedge clk
//   reset_n  in   1   asynchronous, active-low reset
//   wen      in   1   bus write strobe (already qualified by address select)
//   addr     in   32  bus address; only addr[7:0] decoded
//   wdata    in   32  bus write data
//   rdata    out  32  registered read data
//   sck      in   1   SPI clock from master (asynchronous to clk)
//   cs       in   1   SPI chip select from master, active low
//   mosi     in   1   SPI data, master to peripheral
//   miso     out  1   SPI data, peripheral to master
//   rx_irq   out  1   equals STATUS.rx_valid
// BEHAVIOUR
//   Registers (addr[7:0]):
//     0x00 TXDATA  W: tx_buf<=wdata[7:0], tx_full<=1 (overwrites a pending byte)  R: tx_buf
//     0x04 RXDATA  R: last completed byte
//     0x08 STATUS  R: {28'd0, overrun, busy(=~cs_s), tx_full, rx_valid}
//                  W: write-1-to-clear; bit0 clears rx_valid, bit3 clears overrun
//     0x0C FILL    R/W: fill byte [7:0]
//   rdata <= decoded register every clk (reads have no side effects); others read 0; latency 1 clk.
//   sck/cs/mosi pass SYNC_STAGES-flop synchronizers; edges detected on synced sck vs 1-clk delay.
//   Timing limit: each sck high and low phase >= SYNC_STAGES+3 clk cycles.
//   Async reset (reset_n=0): rdata=0, miso=1, rx_irq=0, all flags 0, bit_cnt=0, shift regs 0,
//     rx_data=0, tx_buf=0, FILL=FILL_RESET, sync flops sck=0, cs=1, mosi=1.
//   Frame start: cs_s falls -> bit_cnt<=0; shift_out <= tx_full ? tx_buf : FILL; tx_full<=0.
//   sck rise while cs_s low: shift_in <= {shift_in[6:0], mosi_s}; bit_cnt <= bit_cnt+1 (3-bit wrap).
//   8th rise (bit_cnt==7): rx_data <= {shift_in[6:0], mosi_s}; rx_valid<=1; overrun<=1 if
//     rx_valid already 1 (new byte still overwrites rx_data).
//   sck fall while cs_s low: bit_cnt==0 (byte boundary) -> reload shift_out from tx_buf/FILL as at
//     frame start; else shift_out <= {shift_out[6:0], 1'b0}.
//   miso = cs_s ? 1 : shift_out[7]; registered, valid SYNC_STAGES+2 clk after the sck fall,
//     well ahead of the master's next sampling edge.
//   cs_s rises mid-byte: partial byte discarded, rx_data/rx_valid unchanged, bit_cnt<=0; a TX byte
//     already loaded into shift_out is dropped (not re-queued).
//   Simultaneous events: CPU TXDATA write in same clk as a reload -> reload takes the old tx_buf
//     (or FILL), new byte stays pending, tx_full=1. Byte completion in same clk as W1C of
//     rx_valid -> rx_valid stays 1, overrun not set. Overrun set + W1C overrun same clk -> stays 1.
//   sck edges while cs_s high are ignored.
// TESTING
//   1 Assert reset_n=0 mid-frame -> miso=1, rdata=0, STATUS=0, FILL reads 0xFF, rx_irq=0.
//   2 Write TXDATA=0xA5; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; RXDATA=0x3C; STATUS=0x1.
//   3 No TX written; master sends 0x00 -> master reads 0xFF; write FILL=0x5A, next byte reads 0x5A.
//   4 Master sends 0x11 then 0x22 with no clear -> RXDATA=0x22, STATUS=0x9; write STATUS=0x9 -> 0x0.
//   5 cs high after 4 bits of 0xF0 -> rx_valid=0; next frame 0x81 -> RXDATA=0x81, rx_irq=1.
//   6 TXDATA=0x11,0x22 each written before its reload; 2-byte frame -> master reads 0x11 then 0x22;
//     TXDATA write in the reload clk -> reload sends FILL, tx_full=1 remains.

Source files
------------

// File: rtl/spi_periph_t.sv
`default_nettype none
// ============================================================================
// Module   : spi_periph_t
// Brief    : Memory-mapped SPI target (mode 0, MSB first, 8-bit frames) with
//            RX register, single-entry TX buffer, fill byte and status flags.
// Revision : 1.0 - initial release
// ============================================================================
module spi_periph_t #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_RESET  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        rx_irq
);

  localparam logic [7:0] c_addr_txdata = 8'h00;
  localparam logic [7:0] c_addr_rxdata = 8'h04;
  localparam logic [7:0] c_addr_status = 8'h08;
  localparam logic [7:0] c_addr_fill   = 8'h0C;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic        sck_dly_q, sck_dly_d;
  logic        cs_dly_q, cs_dly_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic        tx_full_q, tx_full_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  fill_q, fill_d;
  logic [31:0] rdata_q, rdata_d;
  logic        miso_q, miso_d;

  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall;
  logic       wr_tx, wr_status, wr_fill, clr_rx, clr_ovr, byte_done;
  logic [7:0] reload_byte;
  logic       unused_bits;

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_dly_q;
  assign sck_fall    = ~sck_s & sck_dly_q;
  assign cs_fall     = ~cs_s & cs_dly_q;
  assign reload_byte = tx_full_q ? tx_buf_q : fill_q;
  assign wr_tx       = wen && (addr[7:0] == c_addr_txdata);
  assign wr_status   = wen && (addr[7:0] == c_addr_status);
  assign wr_fill     = wen && (addr[7:0] == c_addr_fill);
  assign clr_rx      = wr_status & wdata[0];
  assign clr_ovr     = wr_status & wdata[3];
  assign unused_bits = ^{addr[31:8], wdata[31:8]};

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_dly_d   = sck_s;
    cs_dly_d    = cs_s;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rx_data_d   = rx_data_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    fill_d      = fill_q;
    byte_done   = 1'b0;

    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (cs_fall) begin
      bit_cnt_d   = 3'd0;
      shift_out_d = reload_byte;
      tx_full_d   = 1'b0;
    end else begin
      if (sck_rise) begin
        shift_in_d = {shift_in_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        byte_done  = (bit_cnt_q == 3'd7);
      end
      if (sck_fall) begin
        if (bit_cnt_q == 3'd0) begin
          shift_out_d = reload_byte;
          tx_full_d   = 1'b0;
        end else begin
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
    end

    if (byte_done) rx_data_d = {shift_in_q[6:0], mosi_s};

    // Clears apply first so a same-cycle completion or overrun wins.
    if (clr_rx)  rx_valid_d = 1'b0;
    if (clr_ovr) overrun_d  = 1'b0;
    if (byte_done) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q && !clr_rx) overrun_d = 1'b1;
    end

    // A CPU write lands after any reload so the new byte stays pending.
    if (wr_tx) begin
      tx_buf_d  = wdata[7:0];
      tx_full_d = 1'b1;
    end
    if (wr_fill) fill_d = wdata[7:0];

    case (addr[7:0])
      c_addr_txdata: rdata_d = {24'd0, tx_buf_q};
      c_addr_rxdata: rdata_d = {24'd0, rx_data_q};
      c_addr_status: rdata_d = {28'd0, overrun_q, ~cs_s, tx_full_q, rx_valid_q};
      c_addr_fill:   rdata_d = {24'd0, fill_q};
      default:       rdata_d = 32'd0;
    endcase

    miso_d = cs_s ? 1'b1 : shift_out_q[7];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '1;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      rx_data_q   <= 8'd0;
      tx_buf_q    <= 8'd0;
      tx_full_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      fill_q      <= FILL_RESET;
      rdata_q     <= 32'd0;
      miso_q      <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      cs_dly_q    <= cs_dly_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rx_data_q   <= rx_data_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      fill_q      <= fill_d;
      rdata_q     <= rdata_d;
      miso_q      <= miso_d;
    end
  end

  assign rdata  = rdata_q;
  assign miso   = miso_q;
  assign rx_irq = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_periph_t.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_periph_t
// Brief    : Scoreboard bench for spi_periph_t: directed bus and SPI stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_periph_t;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic        rx_irq;

  always #5 clk = ~clk;

  spi_periph_t #(.SYNC_STAGES(2), .FILL_RESET(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso), .rx_irq(rx_irq)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t byte_q[$];
  exp_t pin_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rd_req = 1'b0;
  logic pin_req = 1'b0;
  logic obs_valid = 1'b0;
  logic [7:0] obs_byte = 8'd0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic empty_fail(input string chan);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT output with no expected entry queued", chan);
  endtask

  // Monitor: pops one expectation per presented output and compares.
  always @(posedge clk) begin : mon
    exp_t e;
    if (rd_req || pin_req || obs_valid) begin
      #1;
      if (rd_req) begin
        if (rd_q.size() == 0) empty_fail("rd_queue");
        else begin e = rd_q.pop_front(); compare(e.name, rdata, e.val); end
      end
      if (pin_req) begin
        if (pin_q.size() == 0) empty_fail("pin_queue");
        else begin e = pin_q.pop_front(); compare(e.name, {30'd0, miso, rx_irq}, e.val); end
      end
      if (obs_valid) begin
        if (byte_q.size() == 0) empty_fail("miso_queue");
        else begin e = byte_q.pop_front(); compare(e.name, {24'd0, obs_byte}, e.val); end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr = {24'd0, a}; wdata = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_q.push_back(exp_t'{name, exp});
    addr = {24'd0, a}; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic pins(input logic m, input logic irq, input string name);
    pin_q.push_back(exp_t'{name, {30'd0, m, irq}});
    pin_req = 1'b1;
    @(negedge clk);
    pin_req = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  // Mode-0 master: drive mosi while sck low, sample miso just before the rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, input logic chk,
                      input logic [7:0] exp, input string name);
    logic [7:0] rx;
    rx = 8'd0;
    if (chk) byte_q.push_back(exp_t'{name, {24'd0, exp}});
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    if (chk) begin
      obs_byte = rx; obs_valid = 1'b1;
      @(negedge clk);
      obs_valid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL timeout: simulation did not finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin : stim
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);

    // Reset asserted in the middle of a frame with a TX byte written.
    bus_write(8'h00, 32'h99);
    cs_low();
    xfer(8'hE0, 3, 1'b0, 8'h00, "none");
    reset_n = 1'b0;
    wait_clk(1);
    pins(1'b1, 1'b0, "rst_pins");
    bus_read(8'h0C, 32'h0, "rst_rdata_held");
    cs = 1'b1; mosi = 1'b1;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(4);
    bus_read(8'h08, 32'h0,  "rst_status");
    bus_read(8'h0C, 32'hFF, "rst_fill");
    bus_read(8'h04, 32'h0,  "rst_rxdata");
    bus_read(8'h00, 32'h0,  "rst_txdata");

    // TX byte exchanged against master data.
    bus_write(8'h00, 32'hA5);
    cs_low();
    xfer(8'h3C, 8, 1'b1, 8'hA5, "t2_miso");
    cs_high();
    bus_read(8'h04, 32'h3C, "t2_rxdata");
    bus_read(8'h08, 32'h1,  "t2_status");
    pins(1'b1, 1'b1, "t2_irq_set");
    bus_write(8'h08, 32'h1);
    bus_read(8'h08, 32'h0,  "t2_status_cleared");
    pins(1'b1, 1'b0, "t2_irq_clr");

    // Fill byte at reset value, then reprogrammed.
    cs_low();
    xfer(8'h00, 8, 1'b1, 8'hFF, "t3_fill_reset");
    cs_high();
    bus_write(8'h08, 32'h1);
    bus_write(8'h0C, 32'h5A);
    bus_read(8'h0C, 32'h5A, "t3_fill_rd");
    cs_low();
    xfer(8'h00, 8, 1'b1, 8'h5A, "t3_fill_new");
    cs_high();
    bus_read(8'h08, 32'h1, "t3_status");
    bus_write(8'h08, 32'h1);

    // Overrun from two unacknowledged bytes.
    cs_low();
    xfer(8'h11, 8, 1'b1, 8'h5A, "t4_miso0");
    xfer(8'h22, 8, 1'b1, 8'h5A, "t4_miso1");
    cs_high();
    bus_read(8'h04, 32'h22, "t4_rxdata");
    bus_read(8'h08, 32'h9,  "t4_status_ovr");
    bus_write(8'h08, 32'h9);
    bus_read(8'h08, 32'h0,  "t4_status_cleared");

    // Aborted partial byte is discarded.
    cs_low();
    xfer(8'hF0, 4, 1'b0, 8'h00, "none");
    cs_high();
    bus_read(8'h08, 32'h0,  "t5_status_partial");
    bus_read(8'h04, 32'h22, "t5_rxdata_kept");
    cs_low();
    xfer(8'h81, 8, 1'b1, 8'h5A, "t5_miso");
    cs_high();
    bus_read(8'h04, 32'h81, "t5_rxdata");
    pins(1'b1, 1'b1, "t5_irq");
    bus_write(8'h08, 32'h9);

    // Back-to-back TX bytes, second written before its byte-boundary reload.
    bus_write(8'h00, 32'h11);
    cs_low();
    bus_write(8'h00, 32'h22);
    xfer(8'hC3, 8, 1'b1, 8'h11, "t6_miso0");
    xfer(8'h3C, 8, 1'b1, 8'h22, "t6_miso1");
    cs_high();
    bus_read(8'h04, 32'h3C, "t6_rxdata");
    bus_read(8'h08, 32'h9,  "t6_status");
    bus_read(8'h00, 32'h22, "t6_txdata");
    bus_write(8'h08, 32'h9);

    // TXDATA write lands in the same clock as the frame-start reload.
    cs = 1'b0;
    wait_clk(2);
    bus_write(8'h00, 32'h77);
    bus_read(8'h08, 32'h6, "t6b_status_pending");
    wait_clk(HALF);
    xfer(8'h01, 8, 1'b1, 8'h5A, "t6b_miso_fill");
    xfer(8'h02, 8, 1'b1, 8'h77, "t6b_miso_pending");
    cs_high();
    bus_read(8'h08, 32'h9, "t6b_status");
    bus_read(8'h04, 32'h2, "t6b_rxdata");

    wait_clk(4);
    compare("queues_drained", rd_q.size() + byte_q.size() + pin_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
